// File: rtl/sm3_compress_core.sv
// Iterative SM3 compression function CF(V, B): one round per clock, 64 rounds per block,
// with on-chip message expansion over a 16-word sliding window.
module sm3_compress_core #(
  parameter int ROUNDS = 64
) (
  input  logic         input_clk,
  input  logic         input_reset,
  input  logic         input_valid,
  output logic         output_ready,
  input  logic [0:511] input_block,
  input  logic [0:255] input_V,
  output logic         output_valid,
  input  logic         input_ack,
  output logic [0:255] output_V
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [5:0]  LAST_ROUND = 6'(ROUNDS - 1);
  localparam logic [31:0] T_EARLY    = 32'h79cc4519;
  localparam logic [31:0] T_LATE     = 32'h7a879d8a;

  state_t       state;
  logic [5:0]   j;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [0:255] v_save;
  logic [31:0]  w [16];

  logic         early;
  logic [31:0]  t_rot, a12, ss1, ss2, ff, gg, tt1, tt2, w_new;
  logic [0:255] v_next;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] dbl;
    dbl = {x, x} << n;
    return dbl[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
  endfunction

  // NOTE: every signal below is assigned on every pass with no conditional paths, so no latch
  // can be inferred; combinational blocks use blocking '=' so later lines see earlier results.
  always_comb begin
    early  = (j < 6'd16);
    t_rot  = rotl(early ? T_EARLY : T_LATE, j[4:0]);
    a12    = rotl(a, 5'd12);
    ss1    = rotl(a12 + e + t_rot, 5'd7);
    ss2    = ss1 ^ a12;
    ff     = early ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
    gg     = early ? (e ^ f ^ g) : ((e & f) | (~e & g));
    tt1    = ff + d + ss2 + (w[0] ^ w[4]);
    tt2    = gg + h + ss1 + w[0];
    w_new  = p1(w[0] ^ w[7] ^ rotl(w[13], 5'd15)) ^ rotl(w[3], 5'd7) ^ w[10];
    // Digest candidate as it would stand after the current round's register update.
    v_next = {tt1, a, rotl(b, 5'd9), c, p0(tt2), e, rotl(f, 5'd19), g} ^ v_save;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values,
  // which is what makes the A..H and window shifts below behave as parallel moves.
  always_ff @(posedge input_clk) begin
    if (input_reset) begin
      state        <= IDLE;
      output_ready <= 1'b1;
      output_valid <= 1'b0;
      output_V     <= '0;
      j            <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      v_save       <= '0;
      // NOTE: the window is a register array, not RAM, so clearing it on reset is cheap and
      // guarantees an aborted block leaves no stale message words behind.
      for (int k = 0; k < 16; k++) w[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (input_valid && output_ready) begin
            state        <= RUN;
            output_ready <= 1'b0;
            j            <= '0;
            a            <= input_V[0   +: 32];
            b            <= input_V[32  +: 32];
            c            <= input_V[64  +: 32];
            d            <= input_V[96  +: 32];
            e            <= input_V[128 +: 32];
            f            <= input_V[160 +: 32];
            g            <= input_V[192 +: 32];
            h            <= input_V[224 +: 32];
            v_save       <= input_V;
            for (int k = 0; k < 16; k++) w[k] <= input_block[32*k +: 32];
          end
        end

        RUN: begin
          a <= tt1;
          b <= a;
          c <= rotl(b, 5'd9);
          d <= c;
          e <= p0(tt2);
          f <= e;
          g <= rotl(f, 5'd19);
          h <= g;
          for (int k = 0; k < 15; k++) w[k] <= w[k+1];
          w[15] <= w_new;
          j     <= j + 6'd1;
          if (j == LAST_ROUND) begin
            state        <= DONE;
            output_valid <= 1'b1;
            output_V     <= v_next;
          end
        end

        DONE: begin
          if (input_ack) begin
            state        <= IDLE;
            output_valid <= 1'b0;
            output_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_compress_core.sv
// Scoreboard bench for sm3_compress_core: known-answer vectors plus random blocks checked
// against a straightforward SM3 CF model using the full 68-word expansion.
module tb_sm3_compress_core;

  logic         input_clk;
  logic         input_reset;
  logic         input_valid;
  logic         output_ready;
  logic [0:511] input_block;
  logic [0:255] input_V;
  logic         output_valid;
  logic         input_ack;
  logic [0:255] output_V;

  sm3_compress_core #(.ROUNDS(64)) dut (
    .input_clk    (input_clk),
    .input_reset  (input_reset),
    .input_valid  (input_valid),
    .output_ready (output_ready),
    .input_block  (input_block),
    .input_V      (input_V),
    .output_valid (output_valid),
    .input_ack    (input_ack),
    .output_V     (output_V)
  );

  localparam logic [0:255] IV       = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  localparam logic [0:255] ABC_DIG  = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
  localparam logic [0:255] PROBE    = 256'hb9edc12b7380166f29657292172442d7b2ad29f4a96f30bcc550b189e38dee4d;
  localparam logic [0:255] ABCD_DIG = 256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;

  int n_vec = 0;
  int n_mis = 0;
  logic [0:255] sb_q[$];

  initial begin
    input_clk = 1'b0;
    forever #5 input_clk = ~input_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] m_p0(input logic [31:0] x);
    return x ^ m_rotl(x, 9) ^ m_rotl(x, 17);
  endfunction

  function automatic logic [31:0] m_p1(input logic [31:0] x);
    return x ^ m_rotl(x, 15) ^ m_rotl(x, 23);
  endfunction

  function automatic logic [0:255] sm3_cf(input logic [0:255] v, input logic [0:511] blk);
    logic [31:0]  wx [0:67];
    logic [31:0]  wp [0:63];
    logic [31:0]  r  [0:7];
    logic [31:0]  ss1, ss2, tt1, tt2, ffv, ggv, tj;
    logic [0:255] res;
    for (int k = 0; k < 16; k++) wx[k] = blk[32*k +: 32];
    for (int k = 16; k < 68; k++)
      wx[k] = m_p1(wx[k-16] ^ wx[k-9] ^ m_rotl(wx[k-3], 15)) ^ m_rotl(wx[k-13], 7) ^ wx[k-6];
    for (int k = 0; k < 64; k++) wp[k] = wx[k] ^ wx[k+4];
    for (int k = 0; k < 8; k++) r[k] = v[32*k +: 32];
    for (int jj = 0; jj < 64; jj++) begin
      tj  = (jj < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = m_rotl(m_rotl(r[0], 12) + r[4] + m_rotl(tj, jj), 7);
      ss2 = ss1 ^ m_rotl(r[0], 12);
      ffv = (jj < 16) ? (r[0] ^ r[1] ^ r[2]) : ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
      ggv = (jj < 16) ? (r[4] ^ r[5] ^ r[6]) : ((r[4] & r[5]) | (~r[4] & r[6]));
      tt1 = ffv + r[3] + ss2 + wp[jj];
      tt2 = ggv + r[7] + ss1 + wx[jj];
      r[3] = r[2]; r[2] = m_rotl(r[1], 9); r[1] = r[0]; r[0] = tt1;
      r[7] = r[6]; r[6] = m_rotl(r[5], 19); r[5] = r[4]; r[4] = m_p0(tt2);
    end
    for (int k = 0; k < 8; k++) res[32*k +: 32] = r[k] ^ v[32*k +: 32];
    return res;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge input_clk);
      if (output_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_output: got %h expected no result", output_V);
        end else begin
          check("digest", output_V, sb_q.pop_front());
        end
      end
      prev_valid = output_valid;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic accept_block(input logic [0:255] v, input logic [0:511] blk, input logic [0:255] exp);
    int guard;
    guard = 0;
    @(negedge input_clk);
    while (!output_ready && guard < 200) begin
      @(negedge input_clk);
      guard++;
    end
    check("accept_ready", 256'(output_ready), 256'(1));
    input_V     = v;
    input_block = blk;
    input_valid = 1'b1;
    sb_q.push_back(exp);
    @(negedge input_clk);
    input_valid = 1'b0;
  endtask

  // Counts edges from the negedge following the accept edge until output_valid is seen.
  task automatic wait_done(input int start, output int edges);
    edges = start;
    while (!output_valid && edges < 200) begin
      @(negedge input_clk);
      edges++;
    end
  endtask

  task automatic ack_after(input int hold);
    repeat (hold) @(negedge input_clk);
    input_ack = 1'b1;
    @(negedge input_clk);
    input_ack = 1'b0;
    check("ack_ready", 256'(output_ready), 256'(1));
    check("ack_valid", 256'(output_valid), 256'(0));
  endtask

  function automatic logic [0:511] rand_block();
    logic [0:511] blk;
    for (int k = 0; k < 16; k++) blk[32*k +: 32] = $urandom;
    return blk;
  endfunction

  function automatic logic [0:255] rand_v();
    logic [0:255] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [0:511] abc_blk, abcd1, abcd2, rb;
    logic [0:255] chain_v, rv;
    int lat;

    abc_blk = '0;
    abc_blk[0 +: 32]   = 32'h61626380;
    abc_blk[480 +: 32] = 32'h00000018;
    for (int k = 0; k < 16; k++) abcd1[32*k +: 32] = 32'h61626364;
    abcd2 = '0;
    abcd2[0 +: 32]   = 32'h80000000;
    abcd2[480 +: 32] = 32'h00000200;

    input_reset = 1'b1;
    input_valid = 1'b0;
    input_ack   = 1'b0;
    input_V     = '0;
    input_block = '0;
    repeat (3) @(negedge input_clk);
    input_reset = 1'b0;
    check("reset_ready", 256'(output_ready), 256'(1));
    check("reset_valid", 256'(output_valid), 256'(0));
    check("reset_V", output_V, 256'(0));

    // "abc" known answer with exact latency
    accept_block(IV, abc_blk, ABC_DIG);
    wait_done(0, lat);
    check("abc_latency", 256'(lat), 256'(64));
    ack_after(0);

    // probe A..H after the first round
    accept_block(IV, abc_blk, ABC_DIG);
    @(negedge input_clk);
    check("round0_state", {dut.a, dut.b, dut.c, dut.d, dut.e, dut.f, dut.g, dut.h}, PROBE);
    wait_done(1, lat);
    check("probe_latency", 256'(lat), 256'(64));
    ack_after(2);

    // two chained "abcd" blocks, second V taken from the first result
    accept_block(IV, abcd1, sm3_cf(IV, abcd1));
    wait_done(0, lat);
    chain_v = output_V;
    ack_after(1);
    accept_block(chain_v, abcd2, ABCD_DIG);
    wait_done(0, lat);
    ack_after(0);

    // hold in DONE with input_valid toggling
    accept_block(IV, abc_blk, ABC_DIG);
    wait_done(0, lat);
    for (int i = 0; i < 10; i++) begin
      input_valid = i[0];
      input_block = rand_block();
      @(negedge input_clk);
      check("hold_valid", 256'(output_valid), 256'(1));
      check("hold_ready", 256'(output_ready), 256'(0));
      check("hold_V", output_V, ABC_DIG);
    end
    input_valid = 1'b0;
    ack_after(0);
    @(negedge input_clk);
    check("post_hold_idle", 256'(output_ready), 256'(1));

    // reset asserted at round 30
    accept_block(IV, abc_blk, ABC_DIG);
    repeat (30) @(negedge input_clk);
    input_reset = 1'b1;
    @(negedge input_clk);
    input_reset = 1'b0;
    void'(sb_q.pop_back());
    check("abort_ready", 256'(output_ready), 256'(1));
    check("abort_valid", 256'(output_valid), 256'(0));
    check("abort_V", output_V, 256'(0));
    accept_block(IV, abc_blk, ABC_DIG);
    wait_done(0, lat);
    check("post_abort_latency", 256'(lat), 256'(64));
    ack_after(0);

    // input_valid together with input_ack in the DONE cycle
    rv = rand_v();
    rb = rand_block();
    accept_block(rv, rb, sm3_cf(rv, rb));
    wait_done(0, lat);
    rv = rand_v();
    rb = rand_block();
    input_V     = rv;
    input_block = rb;
    input_valid = 1'b1;
    input_ack   = 1'b1;
    @(negedge input_clk);
    input_ack = 1'b0;
    check("ack_cycle_no_accept", 256'(output_ready), 256'(1));
    sb_q.push_back(sm3_cf(rv, rb));
    @(negedge input_clk);
    input_valid = 1'b0;
    check("accept_after_ack", 256'(output_ready), 256'(0));
    wait_done(0, lat);
    check("late_accept_latency", 256'(lat), 256'(64));
    ack_after(0);

    // random blocks with random consumer delays
    for (int i = 0; i < 6; i++) begin
      rv = rand_v();
      rb = rand_block();
      accept_block(rv, rb, sm3_cf(rv, rb));
      wait_done(0, lat);
      check("rand_latency", 256'(lat), 256'(64));
      ack_after(int'($urandom_range(0, 5)));
    end

    repeat (3) @(negedge input_clk);
    check("scoreboard_empty", 256'(sb_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
